// File: rtl/ppi_bus_master.sv
// ppi_bus_master
// Host-side bus initiator for a PPI-style parallel port. Accepts one request
// at a time on a valid/ready port, runs a timed SETUP/STROBE/HOLD/RECOVER bus
// cycle on the PPI CPU pins, and returns a one-cycle completion pulse with
// read data. Reads of the write-only control word are rejected without any
// bus activity.

module ppi_bus_master #(
    parameter int unsigned SETUP_CYC    = 1,
    parameter int unsigned PULSE_CYC    = 2,
    parameter int unsigned HOLD_CYC     = 1,
    parameter int unsigned RECOVERY_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    // request / response port
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [1:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    // PPI CPU interface
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic [1:0] a,
    output logic [7:0] d_out,
    output logic       d_oe,
    input  logic [7:0] d_in
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RECOVER,
        ST_ERR
    } state_t;

    localparam logic [1:0] ADDR_CTRL = 2'b11;

    // Counter reload values: each timed state lasts (load + 1) cycles.
    localparam logic [3:0] SETUP_LOAD    = 4'(SETUP_CYC - 1);
    localparam logic [3:0] PULSE_LOAD    = 4'(PULSE_CYC - 1);
    localparam logic [3:0] HOLD_LOAD     = 4'(HOLD_CYC - 1);
    localparam logic [3:0] RECOVERY_LOAD = 4'(RECOVERY_CYC - 1);

    state_t     state_q,     state_d;
    logic [3:0] cnt_q,       cnt_d;
    logic       is_write_q,  is_write_d;
    logic       cs_n_q,      cs_n_d;
    logic       rd_n_q,      rd_n_d;
    logic       wr_n_q,      wr_n_d;
    logic [1:0] a_q,         a_d;
    logic [7:0] d_out_q,     d_out_d;
    logic       d_oe_q,      d_oe_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_rdata_q, rsp_rdata_d;
    logic       rsp_err_q,   rsp_err_d;

    logic cnt_done;
    assign cnt_done = (cnt_q == 4'd0);

    // Next-state and next-pin computation for the bus cycle sequencer.
    always_comb begin
        // NOTE: every signal gets a default here so no path through the case leaves it unassigned, which would infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_write_d  = is_write_q;
        cs_n_d      = cs_n_q;
        rd_n_d      = rd_n_q;
        wr_n_d      = wr_n_q;
        a_d         = a_q;
        d_out_d     = d_out_q;
        d_oe_d      = d_oe_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (!req_write && (req_addr == ADDR_CTRL)) begin
                        // Control word is write-only: answer with an error, pins stay idle.
                        state_d     = ST_ERR;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d    = ST_SETUP;
                        cnt_d      = SETUP_LOAD;
                        is_write_d = req_write;
                        cs_n_d     = 1'b0;
                        a_d        = req_addr;
                        d_oe_d     = req_write;
                        if (req_write) begin
                            d_out_d = req_wdata;
                        end
                    end
                end
            end

            ST_SETUP: begin
                if (cnt_done) begin
                    state_d = ST_STROBE;
                    cnt_d   = PULSE_LOAD;
                    if (is_write_q) begin
                        wr_n_d = 1'b0;
                    end else begin
                        rd_n_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_STROBE: begin
                if (cnt_done) begin
                    // Read data is sampled on the edge that ends the strobe.
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                    rd_n_d  = 1'b1;
                    wr_n_d  = 1'b1;
                    if (!is_write_q) begin
                        rsp_rdata_d = d_in;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_HOLD: begin
                if (cnt_done) begin
                    state_d     = ST_RECOVER;
                    cnt_d       = RECOVERY_LOAD;
                    cs_n_d      = 1'b1;
                    d_oe_d      = 1'b0;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_RECOVER: begin
                if (cnt_done) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_ERR: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered pin outputs; reset drops the bus to idle immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            is_write_q  <= 1'b0;
            cs_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            a_q         <= 2'b00;
            d_out_q     <= 8'h00;
            d_oe_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            rsp_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_write_q  <= is_write_d;
            cs_n_q      <= cs_n_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            a_q         <= a_d;
            d_out_q     <= d_out_d;
            d_oe_q      <= d_oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign cs_n      = cs_n_q;
    assign rd_n      = rd_n_q;
    assign wr_n      = wr_n_q;
    assign a         = a_q;
    assign d_out     = d_out_q;
    assign d_oe      = d_oe_q;

endmodule

// File: doc/ppi_bus_master.md
Name: ppi_bus_master

Overview:
- Host-side bus initiator that drives the PPI's CPU interface pins (cs_n, rd_n, wr_n, a, d) from a simple valid/ready request port.
- Issues control-word writes (a=2'b11) and port A/B/C reads and writes with programmable setup, strobe, hold and recovery timing.
- Sits between the host/testbench logic and the PPI responder.
- Returns read data and a completion pulse per transaction.

Parameters:
- SETUP_CYC, 1: cycles cs_n/a/data are stable before the strobe falls (legal range 1..15).
- PULSE_CYC, 2: cycles rd_n/wr_n stays low (1..15).
- HOLD_CYC, 1: cycles cs_n/a/data are held after the strobe rises (1..15).
- RECOVERY_CYC, 1: cycles of bus idle before the next transaction may start (1..15).

Ports:
- clk  input  1  single system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  request accepted this cycle when high with req_valid
- req_write  input  1  1 = write, 0 = read
- req_addr  input  2  PPI register select (00 A, 01 B, 10 C, 11 control word)
- req_wdata  input  8  write data / control word
- rsp_valid  output  1  one-cycle completion pulse
- rsp_rdata  output  8  read data, valid with rsp_valid on reads
- rsp_err  output  1  high with rsp_valid when the request was illegal
- cs_n  output  1  PPI chip select, active low
- rd_n  output  1  PPI read strobe, active low
- wr_n  output  1  PPI write strobe, active low
- a  output  2  PPI address
- d_out  output  8  data driven toward the PPI
- d_oe  output  1  d_out drive enable (bus turnaround)
- d_in  input  8  data from the PPI

Behaviour:
- Reset (async, rst_n low) forces state IDLE immediately, regardless of the current state.
  - Reset values: cs_n=1, rd_n=1, wr_n=1, a=0, d_out=0, d_oe=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - req_ready=1 (IDLE).
  - A transaction interrupted mid-strobe is abandoned, with no rsp_valid.
- All PPI pin outputs are registered. No glitches. rd_n and wr_n are never low together.
- req_ready = (state==IDLE). A request is accepted at the rising edge where req_valid&req_ready. req_write/req_addr/req_wdata are latched at that edge.
- FSM: IDLE -> SETUP -> STROBE -> HOLD -> RECOVER -> IDLE. A 4-bit down-counter times each state.
- SETUP (SETUP_CYC cycles): cs_n=0, a=addr. For writes, d_out=wdata and d_oe=1. For reads, d_oe=0.
- STROBE (PULSE_CYC cycles): wr_n=0 (write) or rd_n=0 (read). cs_n, a and d_out are unchanged.
- On reads, d_in is captured into rsp_rdata at the clock edge that ends the last STROBE cycle.
- HOLD (HOLD_CYC cycles): strobe=1. cs_n=0, a and d_out/d_oe are held.
- RECOVER (RECOVERY_CYC cycles): cs_n=1, d_oe=0, a unchanged.
  - rsp_valid=1 for exactly the first RECOVER cycle, for both reads and writes.
  - rsp_err=0.
- rsp_rdata keeps the last read value until the next read. Writes do not change it.
- Illegal request: read with req_addr=2'b11 (control word is write-only).
  - Accepted normally.
  - No bus cycle: all pins stay idle.
  - Next cycle: rsp_valid=1, rsp_err=1, rsp_rdata unchanged, then IDLE.
- Throughput: legal transaction occupies 1 + SETUP_CYC + PULSE_CYC + HOLD_CYC + RECOVERY_CYC cycles between accepts (6 at defaults).
- req_valid held high while busy is ignored until req_ready returns. Back-to-back requests are accepted on the first IDLE cycle.

Test Plan:
1. Reset, then write ctrl word 8'h80 to addr 3 → a=3, d_oe=1, d_out=80 for 1 cycle; then wr_n=0 for exactly 2 cycles; then cs_n=0 with wr_n=1 for 1 cycle; rsp_valid pulses once with rsp_err=0; req_ready high again 6 cycles after accept.
2. Read port B with d_in=8'hA5 during the strobe and d_in=8'h00 outside it → rd_n low 2 cycles, d_oe=0 throughout, rsp_rdata=A5 with rsp_valid.
3. Read addr 3 → cs_n, rd_n and wr_n stay 1; rsp_valid=1 and rsp_err=1 one cycle after accept; rsp_rdata keeps its previous value (A5).
4. req_valid held high with four queued writes → exactly one accept per 6 cycles; rd_n and wr_n never both 0; cs_n high for ≥1 cycle between transactions.
5. Assert rst_n=0 mid-STROBE of a write → cs_n, wr_n and d_oe return to idle asynchronously (before the next edge); no rsp_valid; req_ready=1 after release.
6. Parameters SETUP=3, PULSE=4, HOLD=2, RECOVERY=5 → phase lengths match exactly; accept-to-accept spacing is 15 cycles.
